// File: rtl/mem_arbiter.sv
// Two-requester (fetch = port 0, data = port 1) arbiter onto a single memory port, with a no-ack timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wr_data,
    input  logic                  p0_rd_req,
    input  logic                  p0_wr_req,
    output logic [DATA_WIDTH-1:0] p0_rd_data,
    output logic                  p0_ack,
    output logic                  p0_busy,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wr_data,
    input  logic                  p1_rd_req,
    input  logic                  p1_wr_req,
    output logic [DATA_WIDTH-1:0] p1_rd_data,
    output logic                  p1_ack,
    output logic                  p1_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ack,
    input  logic                  mem_busy,
    output logic                  timeout_err
);
    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_INT  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = LAST_INT[CNT_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [ADDR_WIDTH-1:0] req_addr   [2];
    logic [DATA_WIDTH-1:0] req_wdata  [2];
    logic [1:0]            req_rd;
    logic [1:0]            req_wr;
    logic [ADDR_WIDTH-1:0] slot_addr  [2];
    logic [DATA_WIDTH-1:0] slot_wdata [2];
    logic [1:0]            slot_write;
    logic [1:0]            slot_valid;
    logic [1:0]            slot_clear;

    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wr_data;
    assign req_wdata[1] = p1_wr_data;
    assign req_rd       = {p1_rd_req, p0_rd_req};
    assign req_wr       = {p1_wr_req, p0_wr_req};

    // One-deep request buffer per port; a request arriving while the slot is full is dropped.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic                  valid_reg;
        logic                  write_reg;
        logic [ADDR_WIDTH-1:0] addr_reg;
        logic [DATA_WIDTH-1:0] wdata_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                write_reg <= 1'b0;
                addr_reg  <= '0;
                wdata_reg <= '0;
            end else if (!valid_reg && (req_rd[gi] || req_wr[gi])) begin
                valid_reg <= 1'b1;
                write_reg <= req_wr[gi];
                addr_reg  <= req_addr[gi];
                wdata_reg <= req_wdata[gi];
            end else if (slot_clear[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign slot_valid[gi] = valid_reg;
        assign slot_write[gi] = write_reg;
        assign slot_addr[gi]  = addr_reg;
        assign slot_wdata[gi] = wdata_reg;
    end

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  owner_reg, owner_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wr_data_reg, mem_wr_data_next;
    logic                  mem_rd_req_reg, mem_rd_req_next;
    logic                  mem_wr_req_reg, mem_wr_req_next;
    logic [1:0]            ack_reg, ack_next;
    logic [DATA_WIDTH-1:0] rd_data_reg  [2];
    logic [DATA_WIDTH-1:0] rd_data_next [2];
    logic                  timeout_reg, timeout_next;
    logic                  grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  last_grant_reg, last_grant_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            owner_reg       <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= '0;
            mem_rd_req_reg  <= 1'b0;
            mem_wr_req_reg  <= 1'b0;
            ack_reg         <= '0;
            rd_data_reg[0]  <= '0;
            rd_data_reg[1]  <= '0;
            timeout_reg     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_reg  <= 1'b1;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            owner_reg       <= owner_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wr_data_reg <= mem_wr_data_next;
            mem_rd_req_reg  <= mem_rd_req_next;
            mem_wr_req_reg  <= mem_wr_req_next;
            ack_reg         <= ack_next;
            rd_data_reg[0]  <= rd_data_next[0];
            rd_data_reg[1]  <= rd_data_next[1];
            timeout_reg     <= timeout_next;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_reg  <= last_grant_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        owner_next       = owner_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wr_data_next = mem_wr_data_reg;
        mem_rd_req_next  = 1'b0;
        mem_wr_req_next  = 1'b0;
        ack_next         = '0;
        rd_data_next[0]  = '0;
        rd_data_next[1]  = '0;
        timeout_next     = 1'b0;
        slot_clear       = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_next  = last_grant_reg;
        grant            = (&slot_valid) ? ~last_grant_reg : slot_valid[1];
`else
        grant            = slot_valid[1];
`endif

        case (state_reg)
            IDLE: begin
                if ((|slot_valid) && !mem_busy) begin
                    owner_next       = grant;
                    mem_addr_next    = slot_addr[grant];
                    mem_wr_data_next = slot_wdata[grant];
                    mem_wr_req_next  = slot_write[grant];
                    mem_rd_req_next  = !slot_write[grant];
                    cnt_next         = '0;
                    state_next       = WAIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_next  = grant;
`endif
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    ack_next[owner_reg]     = 1'b1;
                    rd_data_next[owner_reg] = slot_write[owner_reg] ? '0 : mem_rd_data;
                    slot_clear[owner_reg]   = 1'b1;
                    state_next              = IDLE;
                end else begin
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                    // Forced completion looks like an ack with zero data, flagged by timeout_err.
                    if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
                        ack_next[owner_reg]   = 1'b1;
                        slot_clear[owner_reg] = 1'b1;
                        timeout_next          = 1'b1;
                        state_next            = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign p0_busy     = slot_valid[0];
    assign p1_busy     = slot_valid[1];
    assign p0_ack      = ack_reg[0];
    assign p1_ack      = ack_reg[1];
    assign p0_rd_data  = rd_data_reg[0];
    assign p1_rd_data  = rd_data_reg[1];
    assign mem_addr    = mem_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;
    assign mem_rd_req  = mem_rd_req_reg;
    assign mem_wr_req  = mem_wr_req_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8); tie-order expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] p0_addr = '0, p0_wr_data = '0, p1_addr = '0, p1_wr_data = '0;
    logic        p0_rd_req = 1'b0, p0_wr_req = 1'b0, p1_rd_req = 1'b0, p1_wr_req = 1'b0;
    logic [31:0] p0_rd_data, p1_rd_data, mem_addr, mem_wr_data;
    logic        p0_ack, p0_busy, p1_ack, p1_busy, mem_rd_req, mem_wr_req, timeout_err;
    logic [31:0] mem_rd_data = '0;
    logic        mem_ack = 1'b0, mem_busy = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic        first;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_wr_data(p0_wr_data), .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req),
        .p0_rd_data(p0_rd_data), .p0_ack(p0_ack), .p0_busy(p0_busy),
        .p1_addr(p1_addr), .p1_wr_data(p1_wr_data), .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req),
        .p1_rd_data(p1_rd_data), .p1_ack(p1_ack), .p1_busy(p1_busy),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_rd_data(mem_rd_data), .mem_ack(mem_ack), .mem_busy(mem_busy), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int port, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_addr = a; p0_wr_data = d; p0_rd_req = !wr; p0_wr_req = wr;
        end else begin
            p1_addr = a; p1_wr_data = d; p1_rd_req = !wr; p1_wr_req = wr;
        end
        tick();
        p0_rd_req = 1'b0; p0_wr_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b0;
        $display("req  port=%0d wr=%0d addr=0x%08h data=0x%08h", port, wr, a, d);
    endtask

    task automatic chk_req(input string tag, input bit wr, input logic [31:0] a);
        chk({tag, "_rdreq"}, mem_rd_req, wr ? 32'd0 : 32'd1);
        chk({tag, "_wrreq"}, mem_wr_req, wr ? 32'd1 : 32'd0);
        chk({tag, "_addr"}, mem_addr, a);
    endtask

    // Drive mem_ack for one cycle, then check the owner's completion.
    task automatic serve(input string tag, input int port, input bit wr, input logic [31:0] rd);
        mem_ack = 1'b1; mem_rd_data = rd;
        tick();
        mem_ack = 1'b0; mem_rd_data = '0;
        chk({tag, "_ack"},   port == 0 ? p0_ack : p1_ack, 1);
        chk({tag, "_oack"},  port == 0 ? p1_ack : p0_ack, 0);
        chk({tag, "_rdata"}, port == 0 ? p0_rd_data : p1_rd_data, wr ? 32'd0 : rd);
        chk({tag, "_busy"},  port == 0 ? p0_busy : p1_busy, 0);
        chk({tag, "_terr"},  timeout_err, 0);
        $display("done %s port=%0d rdata=0x%08h", tag, port, port == 0 ? p0_rd_data : p1_rd_data);
    endtask

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        // Reset state
        tick(); tick();
        chk("rst_p0ack", p0_ack, 0);  chk("rst_p1ack", p1_ack, 0);
        chk("rst_p0busy", p0_busy, 0); chk("rst_p1busy", p1_busy, 0);
        chk("rst_rdreq", mem_rd_req, 0); chk("rst_wrreq", mem_wr_req, 0);
        chk("rst_addr", mem_addr, 0);   chk("rst_terr", timeout_err, 0);
        rst = 1'b0;
        tick();

        // Single fetch, ack two cycles after the request pulse
        do_req(0, 0, 32'h40, 32'h0);
        chk("fetch_busy", p0_busy, 1);
        chk("fetch_noreq", mem_rd_req, 0);
        tick();
        chk_req("fetch", 0, 32'h40);
        tick();
        chk("fetch_pulse", mem_rd_req, 0);
        chk("fetch_early", p0_ack, 0);
        serve("fetch", 0, 0, 32'h00a00093);
        tick();
        chk("fetch_ack1cyc", p0_ack, 0);

        // Data write with zero-wait ack
        do_req(1, 1, 32'h100, 32'hdeadbeef);
        tick();
        chk_req("wr", 1, 32'h100);
        chk("wr_data", mem_wr_data, 32'hdeadbeef);
        serve("wr", 1, 1, 32'h12345678);

        // First tie
        p0_addr = 32'h8; p0_rd_req = 1'b1; p1_addr = 32'h200; p1_rd_req = 1'b1;
        tick();
        p0_rd_req = 1'b0; p1_rd_req = 1'b0;
        tick();
        chk_req("tie1a", 0, first ? 32'h200 : 32'h8);
        chk("tie1a_obusy", first ? p0_busy : p1_busy, 1);
        serve("tie1a", int'(first), 0, 32'haaaa0001);
        tick();
        chk_req("tie1b", 0, first ? 32'h8 : 32'h200);
        serve("tie1b", int'(!first), 0, 32'hbbbb0002);

        // Port 0 alone, then a second tie: port 1 wins in both builds
        do_req(0, 0, 32'h10, 32'h0);
        tick();
        chk_req("solo", 0, 32'h10);
        serve("solo", 0, 0, 32'h11110000);
        p0_addr = 32'hc; p0_rd_req = 1'b1; p1_addr = 32'h204; p1_wr_req = 1'b1; p1_wr_data = 32'h5;
        tick();
        p0_rd_req = 1'b0; p1_wr_req = 1'b0;
        tick();
        chk_req("tie2a", 1, 32'h204);
        serve("tie2a", 1, 1, 32'h0);
        tick();
        chk_req("tie2b", 0, 32'hc);
        serve("tie2b", 0, 0, 32'h22220000);

        // Downstream busy holds off the grant
        mem_busy = 1'b1;
        do_req(0, 0, 32'h80, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_hold", mem_rd_req, 0);
        end
        mem_busy = 1'b0;
        tick();
        chk_req("busy_rel", 0, 32'h80);
        tick();
        chk("busy_pulse", mem_rd_req, 0);
        serve("busy", 0, 0, 32'h33330000);

        // No ack: forced completion after 8 WAIT cycles
        do_req(1, 0, 32'h300, 32'h0);
        tick();
        chk_req("to", 0, 32'h300);
        mem_rd_data = 32'hffffffff;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_noack", p1_ack, 0);
            chk("to_noerr", timeout_err, 0);
        end
        tick();
        chk("to_ack", p1_ack, 1);
        chk("to_rdata", p1_rd_data, 0);
        chk("to_err", timeout_err, 1);
        chk("to_busy", p1_busy, 0);
        $display("timeout port=1 terr=%0d", timeout_err);
        tick();
        chk("to_err1cyc", timeout_err, 0);
        mem_rd_data = '0;
        do_req(0, 0, 32'h44, 32'h0);
        tick();
        chk_req("after_to", 0, 32'h44);
        serve("after_to", 0, 0, 32'h44440000);

        // Reset mid-WAIT, then a stale ack
        do_req(0, 0, 32'h50, 32'h0);
        tick();
        chk_req("arst", 0, 32'h50);
        rst = 1'b1;
        #1;
        chk("arst_rdreq", mem_rd_req, 0);
        chk("arst_busy", p0_busy, 0);
        chk("arst_addr", mem_addr, 0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rd_data = 32'h55550000;
        tick();
        mem_ack = 1'b0; mem_rd_data = '0;
        chk("stale_p0ack", p0_ack, 0);
        chk("stale_p1ack", p1_ack, 0);
        chk("stale_p0busy", p0_busy, 0);
        chk("stale_p1busy", p1_busy, 0);
        $display("reset mid-wait, stale ack ignored");
        do_req(0, 0, 32'h60, 32'h0);
        tick();
        chk_req("post_rst", 0, 32'h60);
        serve("post_rst", 0, 0, 32'h66660000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
